// File: rtl/fft_spectrum_capture.sv
// Captures the positive-frequency half of each FFT magnitude frame into a ping-pong
// buffer, tracks the frame's peak bin, and replays completed frames over valid/ready.
module fft_spectrum_capture #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned OUT_BINS       = 256,
    parameter int unsigned OUT_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     i_mag_addr,
    input  logic [DATA_WIDTH-1:0]     i_mag_data,
    input  logic                      i_mag_valid,
    input  logic                      i_fft_done,
    output logic [OUT_ADDR_WIDTH-1:0] o_bin_index,
    output logic [DATA_WIDTH-1:0]     o_bin_data,
    output logic                      o_bin_valid,
    input  logic                      i_bin_ready,
    output logic                      o_frame_first,
    output logic                      o_frame_last,
    output logic [OUT_ADDR_WIDTH-1:0] o_peak_bin,
    output logic [DATA_WIDTH-1:0]     o_peak_mag,
    output logic [7:0]                o_drop_count,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_t;

    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_IDX = OUT_ADDR_WIDTH'(OUT_BINS - 1);

    // Both banks share one array; the MSB of the address selects the bank.
    logic [DATA_WIDTH-1:0] mem [0:2*OUT_BINS-1];

    state_t                    state;
    logic                      wr_bank;
    logic [OUT_ADDR_WIDTH-1:0] rd_idx;
    logic [OUT_ADDR_WIDTH-1:0] wr_idx;
    logic                      wr_en;
    logic                      peak_upd;
    logic [OUT_ADDR_WIDTH-1:0] run_peak_bin;
    logic [DATA_WIDTH-1:0]     run_peak_mag;
    logic [OUT_ADDR_WIDTH-1:0] peak_bin_nxt;
    logic [DATA_WIDTH-1:0]     peak_mag_nxt;

    assign wr_idx   = i_mag_addr[OUT_ADDR_WIDTH-1:0];
    assign wr_en    = i_mag_valid && (32'(i_mag_addr) < OUT_BINS);
    // Strictly-greater keeps the lowest index on ties; the DC bin never competes.
    assign peak_upd = wr_en && (wr_idx != '0) && (i_mag_data > run_peak_mag);

    assign peak_bin_nxt = peak_upd ? wr_idx     : run_peak_bin;
    assign peak_mag_nxt = peak_upd ? i_mag_data : run_peak_mag;

    // NOTE: the storage array has no reset so it maps onto block RAM; its contents are
    // undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= i_mag_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_bank       <= 1'b0;
            rd_idx        <= '0;
            run_peak_bin  <= '0;
            run_peak_mag  <= '0;
            o_bin_index   <= '0;
            o_bin_data    <= '0;
            o_bin_valid   <= 1'b0;
            o_frame_first <= 1'b0;
            o_frame_last  <= 1'b0;
            o_peak_bin    <= '0;
            o_peak_mag    <= '0;
            o_drop_count  <= '0;
            o_busy        <= 1'b0;
        end else begin
            // A write in the done cycle is already folded into peak_*_nxt.
            if (i_fft_done) begin
                run_peak_bin <= '0;
                run_peak_mag <= '0;
                if (state == IDLE) begin
                    wr_bank    <= ~wr_bank;
                    o_peak_bin <= peak_bin_nxt;
                    o_peak_mag <= peak_mag_nxt;
                end else if (o_drop_count != 8'hFF) begin
                    o_drop_count <= o_drop_count + 8'd1;
                end
            end else begin
                run_peak_bin <= peak_bin_nxt;
                run_peak_mag <= peak_mag_nxt;
            end

            case (state)
                IDLE: begin
                    if (i_fft_done) begin
                        rd_idx <= '0;
                        o_busy <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    // The read bank is always the one capture is not writing.
                    o_bin_data    <= mem[{~wr_bank, rd_idx}];
                    o_bin_index   <= rd_idx;
                    o_frame_first <= (rd_idx == '0);
                    o_frame_last  <= (rd_idx == LAST_IDX);
                    o_bin_valid   <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (i_bin_ready) begin
                        o_bin_valid   <= 1'b0;
                        o_frame_first <= 1'b0;
                        o_frame_last  <= 1'b0;
                        if (rd_idx == LAST_IDX) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            rd_idx <= rd_idx + OUT_ADDR_WIDTH'(1);
                            state  <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Scoreboard bench for fft_spectrum_capture: expected beats are queued as frames are
// written and popped by a monitor as the replay stream hands them over.
module tb_fft_spectrum_capture;

    localparam int DW  = 24;
    localparam int AW  = 9;
    localparam int OAW = 8;
    localparam int NB  = 256;

    logic           clk;
    logic           rst_n;
    logic [AW-1:0]  i_mag_addr;
    logic [DW-1:0]  i_mag_data;
    logic           i_mag_valid;
    logic           i_fft_done;
    logic [OAW-1:0] o_bin_index;
    logic [DW-1:0]  o_bin_data;
    logic           o_bin_valid;
    logic           i_bin_ready;
    logic           o_frame_first;
    logic           o_frame_last;
    logic [OAW-1:0] o_peak_bin;
    logic [DW-1:0]  o_peak_mag;
    logic [7:0]     o_drop_count;
    logic           o_busy;

    fft_spectrum_capture #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_BINS(NB), .OUT_ADDR_WIDTH(OAW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mag_addr(i_mag_addr), .i_mag_data(i_mag_data), .i_mag_valid(i_mag_valid),
        .i_fft_done(i_fft_done),
        .o_bin_index(o_bin_index), .o_bin_data(o_bin_data), .o_bin_valid(o_bin_valid),
        .i_bin_ready(i_bin_ready),
        .o_frame_first(o_frame_first), .o_frame_last(o_frame_last),
        .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag),
        .o_drop_count(o_drop_count), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OAW-1:0] idx;
        logic [DW-1:0]  data;
        logic           first;
        logic           last;
    } beat_t;

    beat_t   exp_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      beats    = 0;
    int      cyc      = 0;
    bit      bp_mode  = 1'b0;
    bit      pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] img [NB];

    // Scoreboard monitor: samples on the falling edge, between active edges.
    beat_t prev;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        beat_t act;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            act = {o_bin_index, o_bin_data, o_frame_first, o_frame_last};
            if (stalled) begin
                checks++;
                if (!o_bin_valid || act !== prev) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b %h, required valid=1 %h",
                             o_bin_valid, act, prev);
                end
            end
            stalled = 1'b0;
            if (o_bin_valid) begin
                if (i_bin_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat: got idx=%0d data=%0d, required no beat",
                                 o_bin_index, o_bin_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            failures++;
                            $display("FAIL beat: got idx=%0d data=%0d first=%0b last=%0b, required idx=%0d data=%0d first=%0b last=%0b",
                                     o_bin_index, o_bin_data, o_frame_first, o_frame_last,
                                     e.idx, e.data, e.first, e.last);
                        end
                    end
                    beats++;
                end else begin
                    stalled = 1'b1;
                    prev    = act;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        i_bin_ready = bp_mode ? pat[cyc % 4] : 1'b1;
    endtask

    task automatic write_bin(input int addr, input logic [DW-1:0] data);
        i_mag_addr  = AW'(addr);
        i_mag_data  = data;
        i_mag_valid = 1'b1;
        step();
        i_mag_valid = 1'b0;
    endtask

    task automatic write_img();
        for (int i = 0; i < NB; i++) write_bin(i, img[i]);
    endtask

    task automatic push_img();
        beat_t e;
        for (int i = 0; i < NB; i++) begin
            e.idx   = OAW'(i);
            e.data  = img[i];
            e.first = (i == 0);
            e.last  = (i == NB - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_done();
        i_fft_done = 1'b1;
        step();
        i_fft_done = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 4000) begin
            step();
            n++;
        end
        ok = (exp_q.size() == 0) && !o_busy;
    endtask

    task automatic wait_beats(input int target, output bit ok);
        int n = 0;
        while (beats < target && n < 2000) begin
            step();
            n++;
        end
        ok = (beats >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({o_bin_valid, o_busy, o_frame_first, o_frame_last} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, required 0000",
                     {o_bin_valid, o_busy, o_frame_first, o_frame_last});
        end
        checks++;
        if (o_drop_count !== 8'd0 || o_peak_bin !== '0 || o_peak_mag !== '0) begin
            failures++;
            $display("FAIL reset_peak_drop: got drop=%0d bin=%0d mag=%0d, required 0 0 0",
                     o_drop_count, o_peak_bin, o_peak_mag);
        end
        checks++;
        if (o_bin_index !== '0 || o_bin_data !== '0) begin
            failures++;
            $display("FAIL reset_stream: got idx=%0d data=%0d, required 0 0", o_bin_index, o_bin_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_frame();
        bit ok;
        for (int i = 0; i < NB; i++) img[i] = DW'(i * 16);
        write_img();
        for (int a = NB; a < 512; a++) write_bin(a, DW'(a * 16));
        push_img();
        beats = 0;
        i_fft_done = 1'b1;
        step();
        i_fft_done = 1'b0;
        checks++;
        if (o_bin_valid !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL latency_t1: got valid=%0b busy=%0b, required valid=0 busy=1", o_bin_valid, o_busy);
        end
        step();
        checks++;
        if (o_bin_valid !== 1'b1 || o_bin_index !== '0 || o_frame_first !== 1'b1) begin
            failures++;
            $display("FAIL latency_t2: got valid=%0b idx=%0d first=%0b, required 1 0 1",
                     o_bin_valid, o_bin_index, o_frame_first);
        end
        checks++;
        if (o_peak_bin !== 8'd255 || o_peak_mag !== 24'd4080) begin
            failures++;
            $display("FAIL full_peak: got bin=%0d mag=%0d, required 255 4080", o_peak_bin, o_peak_mag);
        end
        wait_idle(ok);
        checks++;
        if (!ok || beats != NB) begin
            failures++;
            $display("FAIL full_drain: got beats=%0d pending=%0d, required 256 0", beats, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int i = 0; i < NB; i++) img[i] = DW'(i * 16);
        write_img();
        push_img();
        beats   = 0;
        bp_mode = 1'b1;
        pulse_done();
        wait_idle(ok);
        bp_mode = 1'b0;
        checks++;
        if (!ok || beats != NB) begin
            failures++;
            $display("FAIL bp_drain: got beats=%0d pending=%0d, required 256 0", beats, exp_q.size());
        end
    endtask

    task automatic test_drop();
        bit ok;
        for (int i = 0; i < NB; i++) img[i] = DW'(i * 16);
        write_img();
        push_img();
        beats = 0;
        pulse_done();
        wait_beats(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drop_reach50: got beats=%0d, required 50", beats);
        end
        for (int i = 0; i < NB; i++) write_bin(i, 24'd1);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL drop_busy: got busy=%0b, required 1", o_busy);
        end
        pulse_done();
        checks++;
        if (o_drop_count !== 8'd1 || o_peak_bin !== 8'd255 || o_peak_mag !== 24'd4080) begin
            failures++;
            $display("FAIL drop_count: got drop=%0d bin=%0d mag=%0d, required 1 255 4080",
                     o_drop_count, o_peak_bin, o_peak_mag);
        end
        wait_idle(ok);
        checks++;
        if (!ok || beats != NB) begin
            failures++;
            $display("FAIL drop_drain: got beats=%0d pending=%0d, required 256 0", beats, exp_q.size());
        end
        for (int i = 0; i < NB; i++) img[i] = 24'd3;
        write_img();
        push_img();
        beats = 0;
        pulse_done();
        checks++;
        if (o_peak_bin !== 8'd1 || o_peak_mag !== 24'd3) begin
            failures++;
            $display("FAIL third_peak: got bin=%0d mag=%0d, required 1 3", o_peak_bin, o_peak_mag);
        end
        wait_idle(ok);
        checks++;
        if (!ok || beats != NB || o_drop_count !== 8'd1) begin
            failures++;
            $display("FAIL third_drain: got beats=%0d drop=%0d, required 256 1", beats, o_drop_count);
        end
    endtask

    task automatic test_peak_rules();
        bit ok;
        for (int i = 0; i < NB; i++) img[i] = '0;
        img[0]  = 24'hFFFFFF;
        img[10] = 24'd500;
        img[20] = 24'd500;
        write_img();
        write_bin(300, 24'h7FFFFF);
        push_img();
        beats = 0;
        pulse_done();
        checks++;
        if (o_peak_bin !== 8'd10 || o_peak_mag !== 24'd500) begin
            failures++;
            $display("FAIL peak_rules: got bin=%0d mag=%0d, required 10 500", o_peak_bin, o_peak_mag);
        end
        wait_idle(ok);
        checks++;
        if (!ok || beats != NB) begin
            failures++;
            $display("FAIL peak_drain: got beats=%0d pending=%0d, required 256 0", beats, exp_q.size());
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        for (int i = 0; i < NB - 1; i++) img[i] = DW'(i + 100);
        img[NB-1] = 24'd7;
        for (int i = 0; i < NB - 1; i++) write_bin(i, img[i]);
        push_img();
        beats       = 0;
        i_mag_addr  = AW'(255);
        i_mag_data  = 24'd7;
        i_mag_valid = 1'b1;
        i_fft_done  = 1'b1;
        step();
        i_mag_valid = 1'b0;
        i_fft_done  = 1'b0;
        checks++;
        if (o_peak_bin !== 8'd254 || o_peak_mag !== 24'd354) begin
            failures++;
            $display("FAIL same_cycle_peak: got bin=%0d mag=%0d, required 254 354", o_peak_bin, o_peak_mag);
        end
        wait_idle(ok);
        checks++;
        if (!ok || beats != NB) begin
            failures++;
            $display("FAIL same_cycle_drain: got beats=%0d pending=%0d, required 256 0", beats, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_replay();
        bit ok;
        for (int i = 0; i < NB; i++) img[i] = DW'(i * 16 + 5);
        write_img();
        push_img();
        beats = 0;
        pulse_done();
        wait_beats(100, ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || o_bin_valid !== 1'b0 || o_busy !== 1'b0 || o_drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: got reached=%0b valid=%0b busy=%0b drop=%0d, required 1 0 0 0",
                     ok, o_bin_valid, o_busy, o_drop_count);
        end
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NB; i++) img[i] = DW'(1000 + i * 3);
        write_img();
        push_img();
        beats = 0;
        pulse_done();
        wait_idle(ok);
        checks++;
        if (!ok || beats != NB || o_peak_bin !== 8'd255 || o_peak_mag !== 24'd1765) begin
            failures++;
            $display("FAIL post_reset_frame: got beats=%0d bin=%0d mag=%0d, required 256 255 1765",
                     beats, o_peak_bin, o_peak_mag);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_mag_addr  = '0;
        i_mag_data  = '0;
        i_mag_valid = 1'b0;
        i_fft_done  = 1'b0;
        i_bin_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_drop();
        test_peak_rules();
        test_same_cycle();
        test_reset_mid_replay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_spectrum_capture.md
Name: fft_spectrum_capture

Overview:
- Sink for the FFT magnitude result stream (bin address, magnitude, valid strobe, done pulse).
- Captures the positive-frequency half of each frame into a ping-pong buffer and tracks that frame's peak bin.
- Replays each completed frame to a downstream consumer (display/UART formatter) over a valid/ready stream.
- Decouples the FFT core, which cannot be stalled, from a slow consumer.

Parameters:
- DATA_WIDTH, 24, magnitude width
- ADDR_WIDTH, 9, width of incoming bin address (512-point FFT)
- OUT_BINS, 256, bins captured and replayed (indices 0..OUT_BINS-1); power of two, <= 2**ADDR_WIDTH
- OUT_ADDR_WIDTH, 8, log2(OUT_BINS)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_mag_addr  in  ADDR_WIDTH  bin index of incoming magnitude
- i_mag_data  in  DATA_WIDTH  unsigned magnitude
- i_mag_valid  in  1  one-cycle strobe qualifying addr/data
- i_fft_done  in  1  one-cycle pulse: current frame complete
- o_bin_index  out  OUT_ADDR_WIDTH  index of replayed bin
- o_bin_data  out  DATA_WIDTH  replayed magnitude
- o_bin_valid  out  1  stream valid
- i_bin_ready  in  1  stream ready
- o_frame_first  out  1  high with beat of index 0
- o_frame_last  out  1  high with beat of index OUT_BINS-1
- o_peak_bin  out  OUT_ADDR_WIDTH  peak bin of the frame being replayed
- o_peak_mag  out  DATA_WIDTH  peak magnitude of the frame being replayed
- o_drop_count  out  8  saturating count of frames dropped
- o_busy  out  1  replay in progress

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - Write bank = 0, read bank = 1.
  - Running peak cleared; FSM in IDLE.
  - RAM contents undefined, not cleared.
  - Asserting reset mid-replay drops o_bin_valid in the same cycle; the frame is abandoned.
- Storage:
  - Two banks of OUT_BINS x DATA_WIDTH, one write port and one registered read port (1-cycle read latency).
- Capture side:
  - Write occurs on i_mag_valid when i_mag_addr < OUT_BINS, into the write bank at i_mag_addr[OUT_ADDR_WIDTH-1:0].
  - Addresses >= OUT_BINS are ignored: not written, no effect on the peak.
  - Bins not written during a frame keep stale contents; no clearing.
- Running peak:
  - Updated on accepted writes with index >= 1 (DC bin excluded).
  - Update only when magnitude is strictly greater than the held peak, so ties keep the lowest index.
  - Reset value: bin 0, magnitude 0.
- On i_fft_done:
  - An i_mag_valid in the same cycle is written and included in the peak first.
  - If FSM is IDLE: swap banks; latch running peak into o_peak_bin/o_peak_mag; clear running peak; FSM -> READ.
  - Else (replay busy): no swap; frame discarded; running peak cleared; o_drop_count += 1, saturating at 255. The write bank is simply overwritten by the next frame.
- Replay FSM:
  - IDLE: o_bin_valid = 0, o_busy = 0.
  - READ: issue RAM read at rd_idx; next state HOLD. o_busy = 1.
  - HOLD: o_bin_valid = 1; o_bin_index = rd_idx; o_bin_data = registered RAM output.
    - Flags: o_frame_first = (rd_idx == 0); o_frame_last = (rd_idx == OUT_BINS-1).
    - Hold all stream outputs stable while i_bin_ready = 0.
    - On handshake with rd_idx == OUT_BINS-1: -> IDLE.
    - On any other handshake: rd_idx + 1, -> READ.
  - rd_idx = 0 on entry from IDLE.
  - Throughput: 1 beat per 2 cycles when ready is held high.
- Latency: i_fft_done sampled high in cycle T from IDLE -> o_bin_valid first high in cycle T+2 with index 0.
- o_peak_* change only at a swap, so they stay stable for a whole replay.
- Capture continues into the write bank during replay; reads and writes never target the same bank.

Test Plan:
- Full frame: write bins 0..511 with mag = addr*16, then done -> 256 beats, beat k data = 16k; first on k=0, last on k=255; peak_bin 255, peak_mag 4080; first valid 2 cycles after done.
- Backpressure: same frame with i_bin_ready toggling 1,0,0,1 -> index/data/flags stable while stalled; all 256 beats delivered in order, none duplicated.
- Drop: second frame (mag = 1) and done while replay of frame 1 is at beat 50 -> o_drop_count = 1; replay still returns frame-1 data. A third frame (mag = 3) after IDLE replays all 3s.
- Peak rules: bin0 = 0xFFFFFF, bins 10 and 20 = 500, others 0 -> peak_bin 10, peak_mag 500. Bin 300 = 0x7FFFFF -> ignored.
- Same-cycle event: final write addr 255 data 7 in the same cycle as done -> beat 255 carries 7.
- Reset mid-replay: rst_n low at beat 100 -> o_bin_valid, o_busy, o_drop_count = 0 immediately. After release, a new frame replays from index 0.
